// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler that lends one shared up-counter to N_REQ requesters.
// Each granted requester gets a cleared counter, count enable up to its own
// terminal value, and a one-cycle done pulse; a withdrawn request aborts the run.
module cnt_rr_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   len,
    input  logic [CNT_W-1:0]         cnt_val,
    output logic                     cnt_clr,
    output logic                     cnt_en,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic [CNT_W-1:0]   len_q;

    logic [CNT_W-1:0]   len_arr [N_REQ];
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               run_hit;
    logic [IDX_W-1:0]   next_ptr;

    // (base + off) mod N_REQ; both operands are below N_REQ so one subtract suffices
    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] base,
                                                   input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // one-hot vector with bit idx set
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // unpack the flat len bus into per-requester terminal values
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_len
        assign len_arr[i] = len[i*CNT_W +: CNT_W];
    end

    // first asserted request searching upward from ptr, wrapping at N_REQ-1
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!pick_vld && req[inc_wrap(ptr, k)]) begin
                pick_vld = 1'b1;
                pick_idx = inc_wrap(ptr, k);
            end
        end
    end

    assign owner_req = req[win];
    assign run_hit   = (cnt_val == len_q);
    assign next_ptr  = inc_wrap(win, 1);

    // enable drops in the same cycle the terminal value is seen or the owner withdraws
    assign cnt_en = (state == S_RUN) && owner_req && !run_hit;
    assign busy   = (state != S_IDLE);

    // scheduler FSM with registered grant, clear and done
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win     <= '0;
            len_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            cnt_clr <= 1'b0;
        end else begin
            done    <= '0;
            cnt_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win     <= pick_idx;
                        len_q   <= len_arr[pick_idx];
                        gnt     <= onehot(pick_idx);
                        cnt_clr <= 1'b1;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (!owner_req) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= S_IDLE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!owner_req) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= S_IDLE;
                    end else if (run_hit) begin
                        done  <= onehot(win);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt   <= '0;
                    ptr   <= next_ptr;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Bench for cnt_rr_sched: models the shared counter, keeps a scoreboard of
// expected grants and done pulses, and checks cycle timing of each scenario.
module tb_cnt_rr_sched;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [N_REQ-1:0] vec;
        logic [CNT_W-1:0] cnt;
    } done_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] len;
    logic [CNT_W-1:0]       cnt_val;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    logic [N_REQ-1:0] exp_gnt_q [$];
    done_t            exp_done_q [$];

    always #5 clk = ~clk;

    cnt_rr_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .cnt_val (cnt_val),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    // shared counter model
    always_ff @(posedge clk) begin
        if (rst)          cnt_val <= '0;
        else if (cnt_clr) cnt_val <= '0;
        else if (cnt_en)  cnt_val <= cnt_val + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: grant order, done vector, final count, enable cycles
    logic [N_REQ-1:0] prev_gnt = '0;
    int               en_cyc   = 0;
    done_t            d;
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'h0);
                else check("gnt_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
                en_cyc = 0;
            end
            if (cnt_en) en_cyc++;
            if (done != '0) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'h0);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_vec", 32'(done), 32'(d.vec));
                    check("done_cnt", 32'(cnt_val), 32'(d.cnt));
                    check("done_en_cycles", en_cyc, 32'(d.cnt));
                end
            end
        end
        prev_gnt = rst ? '0 : gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int en;
        int cyc;
        int ndone;
        bit ok;
        logic [N_REQ-1:0] last;
        int rise [$];

        rst = 1'b1;
        req = '0;
        len = '0;
        repeat (2) step();
        check("rst_gnt",  32'(gnt),     32'h0);
        check("rst_done", 32'(done),    32'h0);
        check("rst_busy", 32'(busy),    32'h0);
        check("rst_en",   32'(cnt_en),  32'h0);
        check("rst_clr",  32'(cnt_clr), 32'h0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        // single job, len 5
        len[0 +: 4] = 4'd5;
        req = 4'b0001;
        exp_gnt_q.push_back(4'b0001);
        exp_done_q.push_back('{vec: 4'b0001, cnt: 4'd5});
        step();
        check("t1_gnt", 32'(gnt),     32'h1);
        check("t1_clr", 32'(cnt_clr), 32'h1);
        check("t1_en0", 32'(cnt_en),  32'h0);
        check("t1_busy", 32'(busy),   32'h1);
        en = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cnt_en) en++;
            if (i == 0) check("t1_clr_off", 32'(cnt_clr), 32'h0);
        end
        check("t1_en_cycles", en, 32'd5);
        check("t1_cnt_end", 32'(cnt_val), 32'd5);
        step();
        check("t1_done", 32'(done), 32'h1);
        req = '0;
        step();
        check("t1_gnt_off", 32'(gnt),  32'h0);
        check("t1_busy_off", 32'(busy), 32'h0);
        check("t1_done_off", 32'(done), 32'h0);

        // all request, len 2 each, from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        len = {4{4'd2}};
        req = 4'b1111;
        foreach (exp_gnt_q[i]) begin end
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b0100);
        exp_gnt_q.push_back(4'b1000);
        exp_gnt_q.push_back(4'b0001);
        exp_done_q.push_back('{vec: 4'b0001, cnt: 4'd2});
        exp_done_q.push_back('{vec: 4'b0010, cnt: 4'd2});
        exp_done_q.push_back('{vec: 4'b0100, cnt: 4'd2});
        exp_done_q.push_back('{vec: 4'b1000, cnt: 4'd2});
        exp_done_q.push_back('{vec: 4'b0001, cnt: 4'd2});
        ok = 1'b0;
        last = '0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (gnt != '0 && last == '0) rise.push_back(c);
            last = gnt;
            if (rise.size() == 5 && done != '0) begin
                req = '0;
                ok = 1'b1;
                break;
            end
        end
        check("t2_complete", 32'(ok), 32'h1);
        check("t2_rises", rise.size(), 32'd5);
        for (int i = 1; i < rise.size(); i++) begin
            check("t2_period", rise[i] - rise[i-1], 32'd6);
        end
        repeat (2) step();

        // zero-length job on requester 2
        len[8 +: 4] = 4'd0;
        req = 4'b0100;
        exp_gnt_q.push_back(4'b0100);
        exp_done_q.push_back('{vec: 4'b0100, cnt: 4'd0});
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cnt_en) en++;
        end
        check("t3_en_never", en, 32'd0);
        check("t3_done", 32'(done), 32'h4);
        req = '0;
        step();

        // maximum length, must stop at 15
        len[4 +: 4] = 4'd15;
        req = 4'b0010;
        exp_gnt_q.push_back(4'b0010);
        exp_done_q.push_back('{vec: 4'b0010, cnt: 4'd15});
        en = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (cnt_en) en++;
        end
        check("t4_done", 32'(done), 32'h2);
        check("t4_en_cycles", en, 32'd15);
        check("t4_cnt", 32'(cnt_val), 32'd15);
        req = '0;
        step();
        check("t4_no_wrap", 32'(cnt_val), 32'd15);
        check("t4_gnt_off", 32'(gnt), 32'h0);

        // abort requester 0 at count 4
        len[0 +: 4] = 4'd10;
        req = 4'b0001;
        exp_gnt_q.push_back(4'b0001);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (cnt_val == 4'd4 && cnt_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reach4", 32'(ok), 32'h1);
        req = '0;
        #1;
        check("t5_en_drop", 32'(cnt_en), 32'h0);
        step();
        check("t5_gnt_off", 32'(gnt),  32'h0);
        check("t5_busy_off", 32'(busy), 32'h0);
        check("t5_no_done", 32'(done), 32'h0);
        check("t5_cnt_held", 32'(cnt_val), 32'd4);
        len[4 +: 4] = 4'd1;
        req = 4'b0011;
        exp_gnt_q.push_back(4'b0010);
        exp_done_q.push_back('{vec: 4'b0010, cnt: 4'd1});
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done != '0) begin
                check("t5_next_owner", 32'(gnt), 32'h2);
                req = '0;
                ok = 1'b1;
                break;
            end
        end
        check("t5_next_done", 32'(ok), 32'h1);
        step();

        // reset in the middle of a run
        len[0 +: 4] = 4'd8;
        req = 4'b0001;
        exp_gnt_q.push_back(4'b0001);
        repeat (4) step();
        check("t6_running", 32'(cnt_en), 32'h1);
        rst = 1'b1;
        req = '0;
        step();
        check("t6_gnt",  32'(gnt),    32'h0);
        check("t6_en",   32'(cnt_en), 32'h0);
        check("t6_busy", 32'(busy),   32'h0);
        check("t6_done", 32'(done),   32'h0);
        rst = 1'b0;
        len[4 +: 4]  = 4'd1;
        len[12 +: 4] = 4'd3;
        req = 4'b1010;
        exp_gnt_q.push_back(4'b0010);
        exp_gnt_q.push_back(4'b1000);
        exp_done_q.push_back('{vec: 4'b0010, cnt: 4'd1});
        exp_done_q.push_back('{vec: 4'b1000, cnt: 4'd3});
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done != '0) begin
                ndone++;
                if (ndone == 2) begin
                    req = '0;
                    break;
                end
            end
        end
        check("t6_jobs", ndone, 32'd2);

        repeat (3) step();
        check("sb_gnt_left",  exp_gnt_q.size(),  32'd0);
        check("sb_done_left", exp_done_q.size(), 32'd0);

        cyc = n_vec;
        $display("== %0d vectors applied, %0d miscompares ==", cyc, n_err);
        $finish;
    end

endmodule
